// File: rtl/debouncer_boton.sv
// Push-button conditioner: synchronises a raw bouncing input into clk_i and only
// accepts a new level after it has been seen for DEBOUNCE_CYCLES consecutive clocks.
module debouncer_boton #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic button_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic {ST_STABLE = 1'b0, ST_COUNT = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_out;
  logic                   r_busy;

  // Plain shift chain; nothing may sit between the metastability stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], button_i};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Qualification FSM; busy mirrors COUNT as a flop so it cannot glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_out   <= IDLE_LEVEL;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_STABLE: begin
          if (w_sync != r_out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_out <= w_sync;
              r_cnt <= '0;
            end else begin
              r_state <= ST_COUNT;
              r_cnt   <= C_ONE;
              r_busy  <= 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        ST_COUNT: begin
          if (w_sync == r_out) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == C_LAST) begin
            r_out   <= w_sync;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign button_o = r_out;
  assign busy_o   = r_busy;

endmodule

// File: tb/tb_debouncer_boton.sv
// Randomised bench for debouncer_boton: a per-clock reference model feeds a queue
// that an independent monitor drains, plus directed latency and reset checks.
module tb_debouncer_boton;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic button_i = 1'b1;
  logic button_o;
  logic busy_o;

  int errors = 0;
  int checks = 0;
  int dut_rises = 0;
  int dut_falls = 0;
  int mdl_rises = 0;
  int mdl_falls = 0;

  debouncer_boton #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .button_i(button_i),
    .button_o(button_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge button_o) dut_rises++;
  always @(negedge button_o) dut_falls++;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: last SYNC raw samples, and how many consecutive
  // synchronised samples disagree with the clean level.
  logic [SYNC-1:0] m_hist = '0;
  logic            m_out = 1'b0;
  int              m_run = 0;
  logic [1:0]      exp_q[$];

  always @(posedge clk_i) begin
    logic seen;
    if (rst_i) begin
      m_hist = '0;
      m_out  = 1'b0;
      m_run  = 0;
    end else begin
      seen = m_hist[SYNC-1];
      if (seen != m_out) begin
        m_run++;
        if (m_run == DEB) begin
          m_out = seen;
          m_run = 0;
          if (seen) mdl_rises++; else mdl_falls++;
        end
      end else begin
        m_run = 0;
      end
      m_hist = {m_hist[SYNC-2:0], button_i};
    end
    exp_q.push_back({m_out, (m_run != 0)});
  end

  always @(posedge clk_i) begin
    logic [1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got empty queue expected an entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_button_o", button_o, e[1]);
      check("sb_busy_o", busy_o, e[0]);
    end
  end

  task automatic hold(input logic lvl, input int n);
    button_i = lvl;
    repeat (n) @(negedge clk_i);
  endtask

  // Releases reset with button_i=1; first capture edge is k=1.
  task automatic latency_after_reset();
    @(negedge clk_i);
    button_i = 1'b1;
    rst_i = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 2) check("lat_busy_e1", busy_o, 1'b0);
      if (k == 3) check("lat_busy_e2", busy_o, 1'b1);
      if (k == 5) check("lat_out_e4", button_o, 1'b0);
      if (k == 6) check("lat_out_e5", button_o, 1'b1);
      if (k == 6) check("lat_busy_e5", busy_o, 1'b0);
    end
    @(negedge clk_i);
  endtask

  task automatic bouncy(input logic lvl);
    int segs;
    segs = $urandom_range(4, 1);
    for (int s = 0; s < segs; s++) begin
      hold(lvl, $urandom_range(3, 1));
      hold(~lvl, $urandom_range(2, 1));
    end
    hold(lvl, DEB + SYNC + 3);
  endtask

  initial begin
    int r0, f0;
    bit got_busy;
    repeat (3) @(negedge clk_i);
    check("rst_button_o", button_o, 1'b0);
    check("rst_busy_o", busy_o, 1'b0);
    latency_after_reset();

    hold(1'b0, 12);
    check("release_low", button_o, 1'b0);

    r0 = dut_rises;
    hold(1'b1, 3);
    hold(1'b0, 12);
    check_int("glitch_no_rise", dut_rises - r0, 0);

    r0 = dut_rises;
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b1, 1); hold(1'b0, 1);
    hold(1'b1, 12);
    check_int("bounce_one_rise", dut_rises - r0, 1);
    hold(1'b0, 12);

    r0 = dut_rises;
    f0 = dut_falls;
    for (int p = 0; p < 10; p++) begin
      bouncy(1'b1);
      bouncy(1'b0);
    end
    check_int("presses_rises", dut_rises - r0, 10);
    check_int("presses_falls", dut_falls - f0, 10);

    got_busy = 1'b0;
    button_i = 1'b1;
    for (int w = 0; w < 10 && !got_busy; w++) begin
      @(posedge clk_i);
      #1;
      got_busy = busy_o;
    end
    check("wait_busy", got_busy, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_out", button_o, 1'b0);
    check("async_rst_busy", busy_o, 1'b0);
    repeat (2) @(negedge clk_i);
    latency_after_reset();

    for (int i = 0; i < 150; i++) begin
      hold(1'($urandom_range(1, 0)), $urandom_range(6, 1));
    end
    hold(1'b0, 12);
    check_int("rand_rises", dut_rises, mdl_rises);
    check_int("rand_falls", dut_falls, mdl_falls);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
